// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared arbiter state encoding, default starvation limit and memory size codes
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        BUSY_IF,
        BUSY_D,
        RESP
    } state_t;

    localparam int STARVE_LIMIT_DEF = 4;

    localparam logic [1:0] SIZE_WORD = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_BYTE = 2'b10;

endpackage

// File: rtl/mem_arbiter.sv
// mem_arbiter: fetch/data arbiter onto one memory port, data-first with a fetch starvation guard
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int STARVE_LIMIT = STARVE_LIMIT_DEF,
    parameter int ADDR_W       = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [31:0]       if_rdata,
    output logic              if_valid,
    output logic              stall_if,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [1:0]        d_size,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [31:0]       d_wdata,
    output logic [31:0]       d_rdata,
    output logic              d_valid,
    output logic              stall_mem,
    output logic              mem_req,
    output logic              mem_we,
    output logic [1:0]        mem_size,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_ready
);

    localparam int            CW  = $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0] LIM = CW'(STARVE_LIMIT);

    state_t              state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic                sel_q, sel_d;
    logic                we_q, we_d;
    logic [1:0]          size_q, size_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [31:0]         wdata_q, wdata_d;
    logic [31:0]         if_rdata_q, if_rdata_d;
    logic [31:0]         d_rdata_q, d_rdata_d;
    logic                grant_dat, grant_if;

    // Data wins in IDLE unless the fetch port has been starved for STARVE_LIMIT grants
    assign grant_dat = state_q == IDLE && d_req && (cnt_q != LIM || !if_req);
    assign grant_if  = state_q == IDLE && !grant_dat && if_req;

    // Next state, starvation counter, command latch on grant and read-data capture
    always_comb begin
        state_d    = state_q == IDLE ? (grant_dat ? BUSY_D : grant_if ? BUSY_IF : IDLE)
                   : state_q == RESP ? IDLE
                   : mem_ready ? RESP : state_q;
        cnt_d      = state_q != IDLE ? cnt_q
                   : (grant_if || !if_req) ? '0
                   : cnt_q == LIM ? cnt_q : cnt_q + CW'(1);
        sel_d      = grant_dat ? 1'b1 : grant_if ? 1'b0 : sel_q;
        we_d       = grant_dat ? d_we : grant_if ? 1'b0 : we_q;
        size_d     = grant_dat ? d_size : grant_if ? SIZE_WORD : size_q;
        addr_d     = grant_dat ? d_addr : grant_if ? if_addr : addr_q;
        wdata_d    = grant_dat ? d_wdata : grant_if ? '0 : wdata_q;
        if_rdata_d = state_q == BUSY_IF && mem_ready ? mem_rdata : if_rdata_q;
        d_rdata_d  = state_q == BUSY_D && mem_ready && !we_q ? mem_rdata : d_rdata_q;
    end

    // State and datapath registers; reset abandons any transaction in flight
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            sel_q      <= 1'b0;
            we_q       <= 1'b0;
            size_q     <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            if_rdata_q <= '0;
            d_rdata_q  <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            sel_q      <= sel_d;
            we_q       <= we_d;
            size_q     <= size_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            if_rdata_q <= if_rdata_d;
            d_rdata_q  <= d_rdata_d;
        end
    end

    assign mem_req   = state_q == BUSY_IF || state_q == BUSY_D;
    assign mem_we    = we_q;
    assign mem_size  = size_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign if_valid  = state_q == RESP && !sel_q;
    assign d_valid   = state_q == RESP && sel_q;
    assign if_rdata  = if_rdata_q;
    assign d_rdata   = d_rdata_q;
    assign stall_if  = if_req && !if_valid;
    assign stall_mem = d_req && !d_valid;

endmodule
